// File: rtl/qtcore_scan_ctrl_if.sv
// Command/result bundle between a host sequencer and qtcore_scan_ctrl.
// Handshake: a command transfers on a clk_in edge where cmd_valid_in and cmd_ready_out are both high.
interface qtcore_scan_ctrl_if #(
    parameter int CHAIN_LEN = 160,
    parameter int CNT_W     = 16
);
    logic                 cmd_valid_in;
    logic                 cmd_ready_out;
    logic [1:0]           cmd_op_in;
    logic [CHAIN_LEN-1:0] load_data_in;
    logic [CNT_W-1:0]     run_max_in;
    logic [CHAIN_LEN-1:0] unload_data_out;
    logic [CNT_W-1:0]     cycles_out;
    logic                 halted_out;
    logic                 done_out;
    logic                 err_out;

    modport master (
        output cmd_valid_in, cmd_op_in, load_data_in, run_max_in,
        input  cmd_ready_out, unload_data_out, cycles_out, halted_out, done_out, err_out
    );

    modport slave (
        input  cmd_valid_in, cmd_op_in, load_data_in, run_max_in,
        output cmd_ready_out, unload_data_out, cycles_out, halted_out, done_out, err_out
    );
endinterface

// File: rtl/qtcore_scan_ctrl.sv
// Scan-chain sequencer for a QTCore: core reset pulse, chain load/unload, budgeted run until halt.
// Define QTCORE_SCAN_CTRL_RUN_EN to enable the RUN command; otherwise op 2 is rejected like op 3.
module qtcore_scan_ctrl #(
    parameter int CHAIN_LEN  = 160,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2,
    parameter int MIN_RUN    = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    qtcore_scan_ctrl_if.slave cmd,
    output logic              core_rst_out,
    output logic              core_scan_enable_out,
    output logic              core_proc_en_out,
    output logic              core_scan_in_out,
    input  logic              core_scan_out_in,
    output logic [2:0]        state_dbg
);
    localparam int SCNT_W = $clog2(CHAIN_LEN + 1);
    localparam int RCNT_W = $clog2(RST_CYCLES + 1);
    localparam logic [SCNT_W-1:0] SHIFT_LAST = SCNT_W'(CHAIN_LEN - 1);
    localparam logic [RCNT_W-1:0] RST_LAST   = RCNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_SHIFT = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] unload_q;
    logic [SCNT_W-1:0]    scnt;
    logic [RCNT_W-1:0]    rcnt;
    logic                 err_q;

    assign cmd.cmd_ready_out   = (state == S_IDLE);
    assign cmd.unload_data_out = unload_q;
    assign cmd.done_out        = (state == S_DONE);
    assign cmd.err_out         = err_q;
    assign core_rst_out         = (state == S_CRST);
    assign core_scan_enable_out = (state == S_SHIFT);
    assign core_scan_in_out     = (state == S_SHIFT) && sreg[CHAIN_LEN-1];
    assign state_dbg            = state;

`ifdef QTCORE_SCAN_CTRL_RUN_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_max;
    logic [CNT_W-1:0] cycles_q;
    logic             halted_q;
    logic             stop;

    // The halt line is ignored for the first MIN_RUN cycles; the budget check keeps cnt from wrapping.
    assign stop = (cnt == run_max) || ((cnt >= CNT_W'(MIN_RUN)) && core_scan_out_in);
    assign core_proc_en_out = (state == S_RUN) && !stop;
    assign cmd.cycles_out   = cycles_q;
    assign cmd.halted_out   = halted_q;
`else
    logic run_unused;
    assign run_unused       = ^{cmd.run_max_in, MIN_RUN > 0};
    assign core_proc_en_out = 1'b0;
    assign cmd.cycles_out   = '0;
    assign cmd.halted_out   = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            sreg     <= '0;
            unload_q <= '0;
            scnt     <= '0;
            rcnt     <= '0;
            err_q    <= 1'b0;
`ifdef QTCORE_SCAN_CTRL_RUN_EN
            cnt      <= '0;
            run_max  <= '0;
            cycles_q <= '0;
            halted_q <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid_in) begin
                        case (cmd.cmd_op_in)
                            2'd0: begin
                                rcnt  <= '0;
                                state <= S_CRST;
                            end
                            2'd1: begin
                                sreg  <= cmd.load_data_in;
                                scnt  <= '0;
                                state <= S_SHIFT;
                            end
`ifdef QTCORE_SCAN_CTRL_RUN_EN
                            2'd2: begin
                                cnt     <= '0;
                                run_max <= cmd.run_max_in;
                                state   <= S_RUN;
                            end
`endif
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                S_CRST: begin
                    if (rcnt == RST_LAST) state <= S_DONE;
                    else                  rcnt  <= rcnt + 1'b1;
                end
                S_SHIFT: begin
                    // MSB leaves toward the core while the core's scan output enters at bit 0.
                    sreg <= {sreg[CHAIN_LEN-2:0], core_scan_out_in};
                    scnt <= scnt + 1'b1;
                    if (scnt == SHIFT_LAST) begin
                        unload_q <= {sreg[CHAIN_LEN-2:0], core_scan_out_in};
                        state    <= S_DONE;
                    end
                end
`ifdef QTCORE_SCAN_CTRL_RUN_EN
                S_RUN: begin
                    if (stop) begin
                        halted_q <= core_scan_out_in;
                        cycles_q <= cnt;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
